// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, SR/Cause field positions,
// exception codes and the exception handler address.
package cp0_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam int unsigned SR_IE          = 0;
    localparam int unsigned SR_EXL         = 1;
    localparam int unsigned SR_IM_LO       = 10;
    localparam int unsigned CAUSE_EXC_LO   = 2;
    localparam int unsigned CAUSE_IP_LO    = 10;
    localparam int unsigned CAUSE_BD       = 31;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_t;

    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

endpackage

// File: rtl/cp0_exc_ctrl.sv
// M-stage coprocessor-0: SR/Cause/EPC/PRId, interrupt and exception
// detection, and the combinational flush/redirect request.
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID     = 32'h2020_0000,
    parameter int unsigned HW_INT_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         pc_m,
    input  logic [4:0]          exc_code_m,
    input  logic                bd_m,
    input  logic [HW_INT_W-1:0] hw_int,
    input  logic                we,
    input  logic [4:0]          addr,
    input  logic [31:0]         din,
    input  logic                eret_m,
    output logic [31:0]         dout,
    output logic [31:0]         epc,
    output logic                req
);

    logic [HW_INT_W-1:0] im;
    logic                exl;
    logic                ie;
    logic                bd;
    logic [HW_INT_W-1:0] ip;
    logic [4:0]          exc_code;
    logic [31:2]         epc_hi;

    logic        int_pend;
    logic        exc_pend;
    logic [31:2] epc_next;
    logic [31:0] sr_rd;
    logic [31:0] cause_rd;
    logic        unused_pc_bits;

    assign int_pend = (|(hw_int & im)) & ie & ~exl;
    assign exc_pend = (exc_code_m != 5'd0) & ~exl;
    assign req      = int_pend | exc_pend;

    // Word-aligned EPC: (pc - 4)[31:2] equals pc[31:2] - 1 modulo 2^30.
    assign epc_next       = bd_m ? (pc_m[31:2] - 30'd1) : pc_m[31:2];
    assign unused_pc_bits = ^pc_m[1:0];
    assign epc            = {epc_hi, 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= '0;
            exc_code <= '0;
            epc_hi   <= '0;
        end else begin
            ip <= hw_int;
            if (req) begin
                exl      <= 1'b1;
                bd       <= bd_m;
                exc_code <= int_pend ? EXC_INT : exc_code_m;
                epc_hi   <= epc_next;
            end else if (we) begin
                case (addr)
                    CP0_SR: begin
                        im  <= din[SR_IM_LO +: HW_INT_W];
                        exl <= din[SR_EXL];
                        ie  <= din[SR_IE];
                    end
                    CP0_EPC: epc_hi <= din[31:2];
                    default: ;
                endcase
            end else if (eret_m) begin
                exl <= 1'b0;
            end
        end
    end

    always_comb begin
        sr_rd                          = '0;
        sr_rd[SR_IM_LO +: HW_INT_W]    = im;
        sr_rd[SR_EXL]                  = exl;
        sr_rd[SR_IE]                   = ie;
        cause_rd                       = '0;
        cause_rd[CAUSE_BD]             = bd;
        cause_rd[CAUSE_IP_LO +: HW_INT_W] = ip;
        cause_rd[CAUSE_EXC_LO +: 5]    = exc_code;
    end

    always_comb begin
        dout = '0;
        case (addr)
            CP0_SR:    dout = sr_rd;
            CP0_CAUSE: dout = cause_rd;
            CP0_EPC:   dout = epc;
            CP0_PRID:  dout = PRID;
            default:   dout = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Scoreboard bench for cp0_exc_ctrl: directed scenarios plus random traffic,
// checked against a register-level reference model.
module tb_cp0_exc_ctrl;

    localparam logic [31:0] PRID = 32'h2020_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_m;
    logic [4:0]  exc_code_m;
    logic        bd_m;
    logic [5:0]  hw_int;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] din;
    logic        eret_m;
    logic [31:0] dout;
    logic [31:0] epc;
    logic        req;

    cp0_exc_ctrl #(.PRID(PRID), .HW_INT_W(6)) dut (
        .clk(clk), .reset(reset), .pc_m(pc_m), .exc_code_m(exc_code_m),
        .bd_m(bd_m), .hw_int(hw_int), .we(we), .addr(addr), .din(din),
        .eret_m(eret_m), .dout(dout), .epc(epc), .req(req)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [31:0] dout;
        logic [31:0] epc;
        logic [4:0]  addr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    // Reference model state: architectural register images.
    logic [31:0] m_sr, m_cause, m_epc;

    task automatic step(input logic r, input logic [31:0] pc, input logic [4:0] ec,
                        input logic b, input logic [5:0] hi, input logic w,
                        input logic [4:0] a, input logic [31:0] d, input logic er);
        exp_t e;
        logic ip_any, ie, exl, intp, excp, rq;
        reset = r; pc_m = pc; exc_code_m = ec; bd_m = b; hw_int = hi;
        we = w; addr = a; din = d; eret_m = er;

        ie   = m_sr[0];
        exl  = m_sr[1];
        ip_any = ((hi & m_sr[15:10]) != 6'd0);
        intp = ip_any && ie && !exl;
        excp = (ec != 5'd0) && !exl;
        rq   = intp || excp;
        e.req  = rq;
        e.epc  = m_epc;
        e.addr = a;
        if (a == 5'd12)      e.dout = m_sr;
        else if (a == 5'd13) e.dout = m_cause;
        else if (a == 5'd14) e.dout = m_epc;
        else if (a == 5'd15) e.dout = PRID;
        else                 e.dout = 32'd0;
        exp_q.push_back(e);

        if (r) begin
            m_sr = 0; m_cause = 0; m_epc = 0;
        end else begin
            m_cause = (m_cause & ~32'h0000_FC00) | (32'(hi) << 10);
            if (rq) begin
                m_sr    = m_sr | 32'h2;
                m_cause = (m_cause & 32'h0000_FC00) | (32'(b) << 31)
                        | (32'(intp ? 5'd0 : ec) << 2);
                m_epc   = (b ? pc - 32'd4 : pc) & 32'hFFFF_FFFC;
            end else if (w) begin
                if (a == 5'd12)      m_sr  = d & 32'h0000_FC03;
                else if (a == 5'd14) m_epc = d & 32'hFFFF_FFFC;
            end else if (er) begin
                m_sr = m_sr & ~32'h2;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a);
        step(1'b0, 32'h0, 5'd0, 1'b0, 6'd0, 1'b0, a, 32'h0, 1'b0);
    endtask

    // Monitor: outputs are combinational, so sample mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (req === e.req) passed++;
                else $display("FAIL req: got %b want %b", req, e.req);
                checks++;
                if (epc === e.epc) passed++;
                else $display("FAIL epc: got %h want %h", epc, e.epc);
                checks++;
                if (dout === e.dout) passed++;
                else $display("FAIL dout addr=%0d: got %h want %h", e.addr, dout, e.dout);
            end
        end
    end

    initial begin
        logic [4:0] codes[7];
        codes = '{5'd0, 5'd0, 5'd0, 5'd4, 5'd5, 5'd10, 5'd12};
        m_sr = 0; m_cause = 0; m_epc = 0;
        reset = 1'b1; pc_m = 0; exc_code_m = 0; bd_m = 0; hw_int = 0;
        we = 0; addr = 0; din = 0; eret_m = 0;
        @(posedge clk);
        #1;

        // Reset state reads
        rd(5'd12); rd(5'd13); rd(5'd14); rd(5'd15); rd(5'd3);

        // Interrupt taken the same cycle it becomes pending
        step(0, 32'h0, 0, 0, 6'd0, 1, 5'd12, 32'h0000_FC01, 0);
        step(0, 32'h0000_3000, 0, 0, 6'b000100, 0, 5'd13, 32'h0, 0);
        step(0, 32'h0000_3004, 0, 0, 6'b000100, 0, 5'd13, 32'h0, 0);
        step(0, 32'h0, 0, 0, 6'b000100, 0, 5'd12, 32'h0, 0);
        step(0, 32'h0, 0, 0, 6'd0, 0, 5'd14, 32'h0, 1);
        rd(5'd12);

        // Exception in a branch-delay slot
        step(0, 32'h0000_3010, 5'd12, 1, 6'd0, 0, 5'd13, 32'h0, 0);
        rd(5'd13); rd(5'd14);
        step(0, 32'h0, 0, 0, 6'd0, 0, 5'd12, 32'h0, 1);

        // Interrupt beats a simultaneous exception; req beats mtc0
        step(0, 32'h0000_3020, 5'd4, 0, 6'b000001, 0, 5'd13, 32'h0, 0);
        rd(5'd13); rd(5'd14);
        step(0, 32'h0, 0, 0, 6'd0, 0, 5'd12, 32'h0, 1);
        step(0, 32'h0000_3020, 5'd4, 0, 6'b000001, 1, 5'd14, 32'h1234_5678, 0);
        rd(5'd14); rd(5'd13);

        // Exception masked while EXL=1, then eret, then mtc0+eret conflict
        step(0, 32'h0000_3050, 5'd10, 0, 6'd0, 0, 5'd14, 32'h0, 0);
        rd(5'd13);
        step(0, 32'h0, 0, 0, 6'd0, 0, 5'd12, 32'h0, 1);
        rd(5'd12);
        step(0, 32'h0000_3060, 5'd5, 0, 6'd0, 0, 5'd12, 32'h0, 0);
        step(0, 32'h0, 0, 0, 6'd0, 1, 5'd14, 32'hABCD_0007, 1);
        rd(5'd12); rd(5'd14);

        // Reset mid-handler dominates a pending exception
        step(0, 32'h0, 0, 0, 6'd0, 0, 5'd12, 32'h0, 1);
        step(0, 32'h0000_3040, 5'd12, 0, 6'd0, 0, 5'd14, 32'h0, 0);
        step(1, 32'h0000_3070, 5'd12, 0, 6'd0, 0, 5'd14, 32'h0, 0);
        rd(5'd12); rd(5'd13); rd(5'd14);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic        r, b, w, er;
            logic [4:0]  ec, a;
            logic [5:0]  hi;
            logic [31:0] pc, d;
            r  = ($urandom_range(0, 59) == 0);
            pc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 99) == 0) pc = 32'h0;
            ec = codes[$urandom_range(0, 6)];
            b  = $urandom_range(0, 1);
            hi = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            w  = ($urandom_range(0, 3) == 0);
            a  = 5'($urandom_range(10, 17));
            d  = $urandom;
            er = ($urandom_range(0, 3) == 0);
            step(r, pc, ec, b, hi, w, a, d, er);
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
